// File: rtl/hdmi_island_packetizer_if.sv
// Packet handoff between the infoframe source and the island packetizer.
// One packet = 24-bit header plus four 56-bit subpackets, all LSB first.
interface hdmi_island_packetizer_if;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [23:0] pkt_header;
    logic [55:0] pkt_sub0;
    logic [55:0] pkt_sub1;
    logic [55:0] pkt_sub2;
    logic [55:0] pkt_sub3;

    modport master (
        output pkt_valid, pkt_header, pkt_sub0, pkt_sub1, pkt_sub2, pkt_sub3,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_header, pkt_sub0, pkt_sub1, pkt_sub2, pkt_sub3,
        output pkt_ready
    );
endinterface

// File: rtl/hdmi_island_packetizer.sv
// HDMI data-island packetizer: buffers one packet and serialises it over 32 beats
// as TERC4 nibbles, appending BCH(64,56)/(32,24) parity on the fly.
module hdmi_island_packetizer (
    input  logic                           pixclk,
    input  logic                           reset,
    hdmi_island_packetizer_if.slave        pkt,
    input  logic                           start,
    input  logic                           hsync,
    input  logic                           vsync,
    output logic                           island_active,
    output logic [3:0]                     data_ch0,
    output logic [3:0]                     data_ch1,
    output logic [3:0]                     data_ch2,
    output logic                           underrun,
    output logic                           start_err
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [4:0]       beat;
    logic             buf_full;
    logic [23:0]      buf_hdr;
    logic [3:0][55:0] buf_sub;
    logic [23:0]      hdr_sh;
    logic [3:0][55:0] sub_sh;
    logic [7:0]       hdr_par;
    logic [3:0][7:0]  sub_par;

    logic             load, emit, accept, ch0_bit;
    logic [4:0]       nb;
    logic [23:0]      src_hdr, nxt_hdr;
    logic [3:0][55:0] src_sub, nxt_sub;
    logic [7:0]       src_hpar, nxt_hpar;
    logic [3:0][7:0]  src_spar, nxt_spar;
    logic [3:0]       c1, c2;

    function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
        return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    assign pkt.pkt_ready = ~buf_full;
    assign accept        = pkt.pkt_valid & ~buf_full;

    // Beat nb is computed from either the buffer (on the start edge) or the
    // pre-shifted working set, so the registered outputs show beat k at t+1+k.
    always_comb begin
        load     = (state == IDLE) && start;
        emit     = load || (state == SEND && beat != 5'd31);
        nb       = load ? 5'd0 : beat + 5'd1;
        src_hdr  = hdr_sh;
        src_sub  = sub_sh;
        src_hpar = hdr_par;
        src_spar = sub_par;
        if (load) begin
            src_hdr  = buf_full ? buf_hdr : '0;
            src_sub  = buf_full ? buf_sub : '0;
            src_hpar = '0;
            src_spar = '0;
        end
        nxt_hdr  = src_hdr >> 1;
        ch0_bit  = src_hpar[7];
        nxt_hpar = {src_hpar[6:0], 1'b0};
        if (nb < 5'd24) begin
            ch0_bit  = src_hdr[0];
            nxt_hpar = bch_step(src_hpar, src_hdr[0]);
        end
        for (int n = 0; n < 4; n++) begin
            nxt_sub[n]  = src_sub[n] >> 2;
            c1[n]       = src_spar[n][7];
            c2[n]       = src_spar[n][6];
            nxt_spar[n] = {src_spar[n][5:0], 2'b00};
            if (nb < 5'd28) begin
                c1[n]       = src_sub[n][0];
                c2[n]       = src_sub[n][1];
                nxt_spar[n] = bch_step(bch_step(src_spar[n], src_sub[n][0]), src_sub[n][1]);
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            buf_full      <= 1'b0;
            buf_hdr       <= '0;
            buf_sub       <= '0;
            hdr_sh        <= '0;
            sub_sh        <= '0;
            hdr_par       <= '0;
            sub_par       <= '0;
            island_active <= 1'b0;
            underrun      <= 1'b0;
            start_err     <= 1'b0;
            data_ch0      <= 4'b1100;
            data_ch1      <= '0;
            data_ch2      <= '0;
        end else begin
            underrun  <= load && !buf_full;
            start_err <= (state == SEND) && start;
            // A packet arriving alongside start waits for the next island.
            if (accept) begin
                buf_full <= 1'b1;
                buf_hdr  <= pkt.pkt_header;
                buf_sub  <= {pkt.pkt_sub3, pkt.pkt_sub2, pkt.pkt_sub1, pkt.pkt_sub0};
            end else if (load) begin
                buf_full <= 1'b0;
            end
            if (emit) begin
                state         <= SEND;
                beat          <= nb;
                hdr_sh        <= nxt_hdr;
                sub_sh        <= nxt_sub;
                hdr_par       <= nxt_hpar;
                sub_par       <= nxt_spar;
                island_active <= 1'b1;
                data_ch0      <= {nb != 5'd0, ch0_bit, vsync, hsync};
                data_ch1      <= c1;
                data_ch2      <= c2;
            end else begin
                state         <= IDLE;
                beat          <= '0;
                island_active <= 1'b0;
                data_ch0      <= {2'b11, vsync, hsync};
                data_ch1      <= '0;
                data_ch2      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_island_packetizer.sv
// Bench for hdmi_island_packetizer: directed parity vectors, island corner cases
// and random traffic against a packet-stream reference model.
module tb_hdmi_island_packetizer;
    typedef struct packed {
        logic [23:0]      hdr;
        logic [3:0][55:0] sub;
    } pkt_t;

    typedef struct {
        pkt_t            p;
        logic [7:0]      hp;
        logic [3:0][7:0] sp;
    } vec_t;

    logic       pixclk = 1'b0;
    logic       reset, start, hsync, vsync;
    logic       island_active, underrun, start_err;
    logic [3:0] data_ch0, data_ch1, data_ch2;

    hdmi_island_packetizer_if pkt_if();

    hdmi_island_packetizer dut (
        .pixclk        (pixclk),
        .reset         (reset),
        .pkt           (pkt_if.slave),
        .start         (start),
        .hsync         (hsync),
        .vsync         (vsync),
        .island_active (island_active),
        .data_ch0      (data_ch0),
        .data_ch1      (data_ch1),
        .data_ch2      (data_ch2),
        .underrun      (underrun),
        .start_err     (start_err)
    );

    always #5 pixclk = ~pixclk;

    int total = 0;
    int bad   = 0;

    // Reference model: buffer occupancy plus the index of the beat on the wire.
    logic             m_full = 1'b0;
    pkt_t             m_buf  = '0;
    int               m_k    = -1;
    logic             m_rst  = 1'b1;
    logic             m_und  = 1'b0;
    logic             m_serr = 1'b0;
    logic [1:0]       m_sync = 2'b00;
    logic [31:0]      m_h    = '0;
    logic [3:0][63:0] m_s    = '0;

    function automatic logic [7:0] bch_bits(input logic [63:0] bits, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ bits[i]) ? 8'hC1 : 8'h00);
        return c;
    endfunction

    // Whole-packet wire streams: data bits followed by parity MSB first.
    function automatic void build(input pkt_t p);
        logic [7:0] par;
        par = bch_bits({40'd0, p.hdr}, 24);
        for (int i = 0; i < 24; i++) m_h[i] = p.hdr[i];
        for (int j = 0; j < 8; j++)  m_h[24+j] = par[7-j];
        for (int n = 0; n < 4; n++) begin
            par = bch_bits({8'd0, p.sub[n]}, 56);
            for (int i = 0; i < 56; i++) m_s[n][i] = p.sub[n][i];
            for (int j = 0; j < 8; j++)  m_s[n][56+j] = par[7-j];
        end
    endfunction

    task automatic mdl_edge();
        logic acc;
        m_und  = 1'b0;
        m_serr = 1'b0;
        m_sync = {vsync, hsync};
        m_rst  = reset;
        if (reset) begin
            m_full = 1'b0;
            m_k    = -1;
        end else begin
            acc = pkt_if.pkt_valid && !m_full;
            if (start && m_k < 0) begin
                if (m_full) begin
                    build(m_buf);
                    m_full = 1'b0;
                end else begin
                    build(pkt_t'(0));
                    m_und = 1'b1;
                end
                m_k = 0;
            end else begin
                if (start) m_serr = 1'b1;
                if (m_k >= 0) m_k = (m_k == 31) ? -1 : m_k + 1;
            end
            if (acc) begin
                m_full = 1'b1;
                m_buf.hdr = pkt_if.pkt_header;
                m_buf.sub = {pkt_if.pkt_sub3, pkt_if.pkt_sub2, pkt_if.pkt_sub1, pkt_if.pkt_sub0};
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", nm, $time, a, e);
        end
    endtask

    task automatic tick();
        logic [3:0] e0, e1, e2;
        @(posedge pixclk);
        mdl_edge();
        #1;
        e1 = '0;
        e2 = '0;
        if (m_rst)        e0 = 4'b1100;
        else if (m_k < 0) e0 = {2'b11, m_sync};
        else              e0 = {m_k != 0, m_h[m_k], m_sync};
        if (m_k >= 0)
            for (int n = 0; n < 4; n++) begin
                e1[n] = m_s[n][2*m_k];
                e2[n] = m_s[n][2*m_k+1];
            end
        chk("island_active", island_active, m_k >= 0);
        chk("data_ch0", data_ch0, e0);
        chk("data_ch1", data_ch1, e1);
        chk("data_ch2", data_ch2, e2);
        chk("underrun", underrun, m_und);
        chk("start_err", start_err, m_serr);
        chk("pkt_ready", pkt_if.pkt_ready, !m_full);
        hsync = 1'($urandom_range(1));
        vsync = 1'($urandom_range(1));
    endtask

    task automatic offer(input pkt_t p);
        pkt_if.pkt_valid  = 1'b1;
        pkt_if.pkt_header = p.hdr;
        pkt_if.pkt_sub0   = p.sub[0];
        pkt_if.pkt_sub1   = p.sub[1];
        pkt_if.pkt_sub2   = p.sub[2];
        pkt_if.pkt_sub3   = p.sub[3];
    endtask

    function automatic pkt_t rnd_pkt();
        pkt_t       p;
        logic [63:0] w;
        p.hdr = 24'($urandom);
        for (int n = 0; n < 4; n++) begin
            w = {$urandom, $urandom};
            p.sub[n] = w[55:0];
        end
        return p;
    endfunction

    vec_t             vt[6];
    logic [31:0]      rh;
    logic [3:0][63:0] rs;
    logic [7:0]       gp;
    int               cnt_a, cnt_e;

    initial begin
        reset = 1'b1; start = 1'b0; hsync = 1'b0; vsync = 1'b0;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_header = '0;
        pkt_if.pkt_sub0 = '0; pkt_if.pkt_sub1 = '0; pkt_if.pkt_sub2 = '0; pkt_if.pkt_sub3 = '0;
        tick(); tick();
        chk("reset_ch0", data_ch0, 4'b1100);
        reset = 1'b0;
        tick();

        // Directed packets with hand-computed parity.
        for (int i = 0; i < 6; i++) begin
            vt[i].p = '0; vt[i].hp = 8'h00; vt[i].sp = '0;
        end
        vt[0].p.hdr = 24'h800000;            vt[0].hp = 8'hC1;
        vt[1].p.hdr = 24'h400000;            vt[1].hp = 8'h43;
        vt[2].p.sub[0] = 56'h80000000000000; vt[2].sp[0] = 8'hC1;
        vt[3].p.sub[1] = 56'h40000000000000; vt[3].sp[1] = 8'h43;
        vt[4].p.hdr = 24'h000001;            vt[4].hp = bch_bits(64'h1, 24);
        vt[4].p.sub[3] = 56'h1;              vt[4].sp[3] = bch_bits(64'h1, 56);
        vt[5].p.sub[2] = 56'h80000000000000; vt[5].sp[2] = 8'hC1;
        vt[5].p.hdr = 24'h800000;            vt[5].hp = 8'hC1;

        for (int i = 0; i < 6; i++) begin
            offer(vt[i].p);
            tick();
            pkt_if.pkt_valid = 1'b0;
            start = 1'b1;
            for (int k = 0; k < 32; k++) begin
                tick();
                start = 1'b0;
                rh[k] = data_ch0[2];
                for (int n = 0; n < 4; n++) begin
                    rs[n][2*k]   = data_ch1[n];
                    rs[n][2*k+1] = data_ch2[n];
                end
            end
            tick();
            chk("tbl_hdr", rh[23:0], vt[i].p.hdr);
            for (int j = 0; j < 8; j++) gp[7-j] = rh[24+j];
            chk("tbl_hpar", gp, vt[i].hp);
            for (int n = 0; n < 4; n++) begin
                chk("tbl_sub", rs[n][55:0], vt[i].p.sub[n]);
                for (int j = 0; j < 8; j++) gp[7-j] = rs[n][56+j];
                chk("tbl_spar", gp, vt[i].sp[n]);
            end
        end

        // Empty buffer: null packet plus underrun.
        start = 1'b1; tick(); start = 1'b0;
        chk("null_underrun", underrun, 1'b1);
        repeat (33) tick();

        // Packet offered together with start waits for the next island.
        offer(rnd_pkt()); start = 1'b1; tick();
        start = 1'b0; pkt_if.pkt_valid = 1'b0;
        chk("bypass_underrun", underrun, 1'b1);
        chk("bypass_held", pkt_if.pkt_ready, 1'b0);
        repeat (33) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (33) tick();

        // A then B, B accepted mid-island, second start at t+40.
        offer(rnd_pkt()); tick(); pkt_if.pkt_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        offer(rnd_pkt()); tick(); pkt_if.pkt_valid = 1'b0;
        repeat (34) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("ab_ready_hold", pkt_if.pkt_ready, 1'b1);
        repeat (33) tick();

        // Start during SEND.
        cnt_a = 0; cnt_e = 0;
        start = 1'b1; tick(); start = 1'b0;
        cnt_a += int'(island_active);
        for (int c = 1; c < 45; c++) begin
            if (c == 10) start = 1'b1;
            tick();
            start = 1'b0;
            cnt_a += int'(island_active);
            cnt_e += int'(start_err);
        end
        chk("serr_count", cnt_e, 1);
        chk("active_len", cnt_a, 32);

        // Reset at beat 15 with a packet buffered.
        offer(rnd_pkt()); tick(); pkt_if.pkt_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        offer(rnd_pkt()); tick(); pkt_if.pkt_valid = 1'b0;
        repeat (14) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_active", island_active, 1'b0);
        chk("abort_ready", pkt_if.pkt_ready, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("abort_underrun", underrun, 1'b1);
        repeat (33) tick();

        // Random traffic.
        for (int c = 0; c < 2500; c++) begin
            start = ($urandom_range(24) == 0);
            reset = ($urandom_range(700) == 0);
            if ($urandom_range(3) == 0) offer(rnd_pkt());
            else pkt_if.pkt_valid = 1'b0;
            tick();
        end
        start = 1'b0; reset = 1'b0; pkt_if.pkt_valid = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hdmi_island_packetizer.md
HDMI_ISLAND_PACKETIZER -- requirements
Module: hdmi_island_packetizer

Interface
REQ-001 SHALL have no parameters; packet is fixed at 32 beats: 24 header bits + 8 BCH parity, and 4 subpackets of 56 data bits + 8 BCH parity each.
REQ-002 pixclk  in  1  pixel clock; all logic is on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pkt_valid  in  1  a packet is presented on pkt_header/pkt_sub*.
REQ-005 pkt_ready  out  1  the holding buffer is empty; the packet is accepted when pkt_valid&pkt_ready.
REQ-006 pkt_header  in  24  packet header HB0..HB2, LSB first.
REQ-007 pkt_sub0..pkt_sub3  in  56 each  subpacket data SB0..SB6, LSB first.
REQ-008 start  in  1  one-cycle pulse marking the first data-period slot of an island.
REQ-009 hsync, vsync  in  1 each  sync levels to embed in channel 0.
REQ-010 island_active  out  1  high while data_ch* carry a packet beat.
REQ-011 data_ch0, data_ch1, data_ch2  out  4 each  TERC4 nibbles for the downstream encoders.
REQ-012 underrun  out  1  one-cycle pulse: start arrived with an empty buffer.
REQ-013 start_err  out  1  one-cycle pulse: start arrived while a packet was still sending.

Function
REQ-014 The block SHALL have a one-entry holding buffer (header + 4 subpackets) and a separate shift/BCH working set.
- pkt_ready = buffer empty.
REQ-015 State machine SHALL have two states, IDLE and SEND, with a 5-bit beat counter.
- IDLE + start -> SEND, beat=0.
- SEND, beat==31 -> IDLE.
REQ-016 On start in IDLE:
- buffer full: its contents load into the working set and the buffer empties; pkt_ready rises the next cycle.
- buffer empty: an all-zero null packet loads and underrun pulses.
REQ-017 A packet accepted in the same cycle as start SHALL NOT bypass the buffer; the null packet is sent and the new packet is held for the next start.
REQ-018 start during SEND SHALL be ignored (the packet continues) and start_err SHALL pulse.
REQ-019 Outputs SHALL be registered; beat k appears at cycle t+1+k for start at cycle t, so island_active is high for exactly cycles t+1..t+32.
REQ-020 data_ch0 SHALL be:
- [3] = 0 on beat 0, 1 on beats 1..31;
- [2] = header bit k for beats 0..23, then header parity MSB first for beats 24..31;
- [1:0] = {vsync,hsync} registered with the same latency.
REQ-021 For subpacket n, data_ch1[n] and data_ch2[n] SHALL be:
- beats 0..27: data_ch1[n] = sub bit 2k, data_ch2[n] = sub bit 2k+1;
- beats 28..31: data_ch1[n] = parity bit 7-2j, data_ch2[n] = parity bit 6-2j, for j = k-28.
REQ-022 BCH update per data bit b SHALL be: code = (code<<1) XOR (code[7]^b ? 8'hC1 : 0).
- Header: one bit per beat.
- Subpackets: two bits per beat, even bit first.
- Parity is cleared at packet load and is not updated during parity beats; those beats only shift it out.
REQ-023 Outside SEND, data_ch0 SHALL be {1,1,vsync,hsync} (registered), data_ch1/2 SHALL be 0 and island_active SHALL be 0.

Reset
REQ-024 On reset: state IDLE, beat 0, buffer empty, working set and parity 0.
REQ-025 On reset: pkt_ready=1, island_active=0, underrun=0, start_err=0, data_ch0=4'b1100, data_ch1=0, data_ch2=0.
REQ-026 Reset mid-SEND SHALL abort the packet immediately (island_active 0 the next cycle) and discard any buffered packet.

Verification
REQ-027 No packet, start at t -> underrun at t+1; 32 beats all zero except ch0[3]=0 at beat 0 and 1 at beats 1..31; pkt_ready stays 1.
REQ-028 pkt_header=24'h800000, subs 0, then start -> ch0[2] is 1 only at beat 23; beats 24..31 give 1,1,0,0,0,0,0,1 (parity 8'hC1).
REQ-029 pkt_sub0 with only bit 55 set, then start -> beat 27 gives ch2[0]=1; beats 28..31 give ch1[0]=1,0,0,0 and ch2[0]=1,0,0,1.
REQ-030 Packet A buffered; packet B offered while A sends; start at t and t+40 -> A then B emitted intact, pkt_ready low from B's acceptance until t+41.
REQ-031 start at t and t+10 -> start_err pulses once; island_active is continuous for 32 cycles only.
REQ-032 Reset asserted at beat 15 with a packet buffered -> island_active 0 and pkt_ready 1 the next cycle; next start gives underrun.
